// File: rtl/hazard3_pmp_fault_log.sv
// hazard3_pmp_fault_log: FIFO of PMP-killed fetch/load/store records for M-mode inspection.
// CSRs: 0xbe0 FLOGSTAT, 0xbe1 FLOGADDR, 0xbe2 FLOGINFO, 0xbe3 FLOGTIME.
// Optional build macro HAZARD3_PMP_FAULT_LOG_TIMESTAMP_EN adds a cycle counter whose value is
// stored with every record and read back through FLOGTIME; without it FLOGTIME reads 0.
module hazard3_pmp_fault_log #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned W_OVF  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic              i_kill,
  input  logic [W_ADDR-1:0] i_addr,
  input  logic              i_m_mode,
  input  logic              d_valid,
  input  logic              d_kill,
  input  logic [W_ADDR-1:0] d_addr,
  input  logic              d_write,
  input  logic              d_m_mode,
  input  logic [11:0]       cfg_addr,
  input  logic              cfg_wen,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  output logic              irq
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  // Record storage; info is {m_mode, write, is_fetch}
  logic [W_ADDR-1:0] e_addr [DEPTH];
  logic [2:0]        e_info [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr, slot_i;
  logic [LVL_W-1:0] level, level_nx, space;
  logic [W_OVF-1:0] ovf, ovf_nx;
  logic [W_OVF:0]   ovf_sum;
  logic [1:0]       ovf_inc;
  logic             en, irq_en, en_nx, irq_en_nx, irq_nx;
  logic             stat_wr, clear, pop, push_d, push_i, store_d, store_i, nonempty;
  logic             unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:4];
  assign nonempty     = (level != '0);

`ifdef HAZARD3_PMP_FAULT_LOG_TIMESTAMP_EN
  logic [31:0] cyc;
  logic [31:0] e_ts [DEPTH];

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 32'd1;
  end
`endif

  // Next-state: clear overrides pop and pushes; d is placed before i, so with one free
  // slot the i fault is the one counted as overflow
  always_comb begin
    stat_wr   = cfg_wen && (cfg_addr == 12'hbe0);
    clear     = stat_wr & cfg_wdata[3];
    pop       = stat_wr & cfg_wdata[2] & nonempty & ~clear;
    push_d    = en & d_valid & d_kill & ~clear;
    push_i    = en & i_valid & i_kill & ~clear;
    space     = LVL_W'(DEPTH) - level + LVL_W'(pop);
    store_d   = push_d & (space != '0);
    store_i   = push_i & (store_d ? (space >= LVL_W'(2)) : (space != '0));
    slot_i    = wr_ptr + PTR_W'(store_d);
    ovf_inc   = {1'b0, push_d & ~store_d} + {1'b0, push_i & ~store_i};
    ovf_sum   = {1'b0, ovf} + (W_OVF + 1)'(ovf_inc);
    ovf_nx    = clear ? '0 : (ovf_sum[W_OVF] ? '1 : ovf_sum[W_OVF-1:0]);
    level_nx  = clear ? '0 : level - LVL_W'(pop) + LVL_W'(store_d) + LVL_W'(store_i);
    en_nx     = stat_wr ? cfg_wdata[0] : en;
    irq_en_nx = stat_wr ? cfg_wdata[1] : irq_en;
    irq_nx    = irq_en_nx & (level_nx != '0);
  end

  // State update: pointers, level, counters, control bits and record writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      ovf    <= '0;
      en     <= 1'b0;
      irq_en <= 1'b0;
      irq    <= 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        e_addr[k] <= '0;
        e_info[k] <= '0;
`ifdef HAZARD3_PMP_FAULT_LOG_TIMESTAMP_EN
        e_ts[k]   <= '0;
`endif
      end
    end else begin
      level  <= level_nx;
      ovf    <= ovf_nx;
      en     <= en_nx;
      irq_en <= irq_en_nx;
      irq    <= irq_nx;
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        rd_ptr <= rd_ptr + PTR_W'(pop);
        wr_ptr <= wr_ptr + PTR_W'(store_d) + PTR_W'(store_i);
      end
      if (store_d) begin
        e_addr[wr_ptr] <= d_addr;
        e_info[wr_ptr] <= {d_m_mode, d_write, 1'b0};
`ifdef HAZARD3_PMP_FAULT_LOG_TIMESTAMP_EN
        e_ts[wr_ptr]   <= cyc;
`endif
      end
      if (store_i) begin
        e_addr[slot_i] <= i_addr;
        e_info[slot_i] <= {i_m_mode, 1'b0, 1'b1};
`ifdef HAZARD3_PMP_FAULT_LOG_TIMESTAMP_EN
        e_ts[slot_i]   <= cyc;
`endif
      end
    end
  end

  // CSR read mux; head fields read 0 while empty
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      12'hbe0: begin
        cfg_rdata[0]     = en;
        cfg_rdata[1]     = irq_en;
        cfg_rdata[8:4]   = 5'(level);
        cfg_rdata[23:16] = 8'(ovf);
        cfg_rdata[31]    = nonempty;
      end
      12'hbe1: if (nonempty) cfg_rdata = 32'(e_addr[rd_ptr]);
      12'hbe2: if (nonempty) cfg_rdata[2:0] = e_info[rd_ptr];
`ifdef HAZARD3_PMP_FAULT_LOG_TIMESTAMP_EN
      12'hbe3: if (nonempty) cfg_rdata = e_ts[rd_ptr];
`endif
      default: cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hazard3_pmp_fault_log.sv
// tb_hazard3_pmp_fault_log: directed bench with a queue-based reference model of the fault log.
module tb_hazard3_pmp_fault_log;

  localparam int unsigned DEPTH = 4;

  logic        clk, rst_n;
  logic        i_valid, i_kill, i_m_mode, d_valid, d_kill, d_write, d_m_mode;
  logic [31:0] i_addr, d_addr;
  logic [11:0] cfg_addr;
  logic        cfg_wen;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        irq;

  hazard3_pmp_fault_log #(.DEPTH(DEPTH), .W_ADDR(32), .W_OVF(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_kill(i_kill), .i_addr(i_addr), .i_m_mode(i_m_mode),
    .d_valid(d_valid), .d_kill(d_kill), .d_addr(d_addr), .d_write(d_write), .d_m_mode(d_m_mode),
    .cfg_addr(cfg_addr), .cfg_wen(cfg_wen), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  info;
  } rec_t;

  rec_t        mq[$];
  logic        m_en, m_irq_en, m_irq;
  int unsigned m_ovf;
  int          checks = 0;
  int          failures = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic read_csr(input logic [11:0] a, output logic [31:0] v);
    cfg_addr = a;
    #1;
    v = cfg_rdata;
  endtask

  task automatic model_push(input rec_t r);
    if (mq.size() < DEPTH) mq.push_back(r);
    else if (m_ovf < 255) m_ovf++;
  endtask

  // Reference model advanced with whatever inputs are applied for the coming edge
  task automatic model_step();
    logic pd, pi, sw;
    rec_t r;
    if (!rst_n) begin
      mq.delete();
      m_en = 0; m_irq_en = 0; m_irq = 0; m_ovf = 0;
      return;
    end
    pd = m_en & d_valid & d_kill;
    pi = m_en & i_valid & i_kill;
    sw = cfg_wen && (cfg_addr == 12'hbe0);
    if (sw && cfg_wdata[3]) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      if (sw && cfg_wdata[2] && mq.size() > 0) void'(mq.pop_front());
      if (pd) begin r.addr = d_addr; r.info = {d_m_mode, d_write, 1'b0}; model_push(r); end
      if (pi) begin r.addr = i_addr; r.info = {i_m_mode, 1'b0, 1'b1}; model_push(r); end
    end
    if (sw) begin
      m_en = cfg_wdata[0];
      m_irq_en = cfg_wdata[1];
    end
    m_irq = m_irq_en && (mq.size() > 0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    d_valid = 0; d_kill = 0; d_write = 0; d_m_mode = 0;
    i_valid = 0; i_kill = 0; i_m_mode = 0;
    cfg_wen = 0; cfg_wdata = '0;
  endtask

  task automatic d_fault(input logic [31:0] a, input logic w, input logic m);
    d_valid = 1; d_kill = 1; d_addr = a; d_write = w; d_m_mode = m;
  endtask

  task automatic i_fault(input logic [31:0] a, input logic m);
    i_valid = 1; i_kill = 1; i_addr = a; i_m_mode = m;
  endtask

  task automatic stat_write(input logic [31:0] v);
    cfg_addr = 12'hbe0; cfg_wen = 1; cfg_wdata = v;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v, e;
    read_csr(12'hbe0, v);
    e = '0;
    e[0] = m_en;
    e[1] = m_irq_en;
    e[8:4] = 5'(mq.size());
    e[23:16] = 8'(m_ovf);
    e[31] = (mq.size() != 0);
    cmp({tag, ".stat"}, v, e);
    read_csr(12'hbe1, v);
    cmp({tag, ".addr"}, v, (mq.size() != 0) ? mq[0].addr : 32'h0);
    read_csr(12'hbe2, v);
    cmp({tag, ".info"}, v, (mq.size() != 0) ? {29'h0, mq[0].info} : 32'h0);
    cmp({tag, ".irq"}, {31'h0, irq}, {31'h0, m_irq});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, t0, t1;
    rst_n = 0;
    d_valid = 0; d_kill = 0; d_write = 0; d_m_mode = 0; d_addr = '0;
    i_valid = 0; i_kill = 0; i_m_mode = 0; i_addr = '0;
    cfg_addr = '0; cfg_wen = 0; cfg_wdata = '0;
    tick(); tick();
    rst_n = 1;
    check_all("reset");

    stat_write(32'h1); tick(); check_all("en");

    d_fault(32'h2000_0010, 1, 0); tick(); check_all("d_store");
    read_csr(12'hbe2, v); cmp("d_store.info_const", v, 32'h2);

    stat_write(32'h7); tick(); check_all("pop1");
    i_fault(32'h0000_1002, 1); tick(); check_all("i_fault_irq");
    cmp("i_fault_irq.level", {31'h0, irq}, 32'h1);
    stat_write(32'h7); tick(); check_all("pop2");
    stat_write(32'h7); tick(); check_all("pop_empty");

    d_valid = 1; d_addr = 32'hdead_0000; tick();
    i_kill = 1; i_addr = 32'hbeef_0000; tick();
    check_all("no_kill");

    for (int k = 0; k < DEPTH - 1; k++) begin
      d_fault(32'h10 * (k + 1), 1'(k), 1'(k >> 1)); tick();
    end
    check_all("fill");
    d_fault(32'h100, 0, 0); i_fault(32'h200, 0); tick(); check_all("dual_1slot");
    stat_write(32'h7); d_fault(32'h300, 1, 1); tick(); check_all("full_pop_push");
    stat_write(32'h7); d_fault(32'h400, 0, 1); i_fault(32'h500, 1); tick(); check_all("full_pop_dual");
    for (int k = 0; k < 300; k++) begin
      d_fault(32'h600 + 32'(k), 0, 0); tick();
    end
    check_all("ovf_sat");
    read_csr(12'hbe0, v); cmp("ovf_sat.cnt", {24'h0, v[23:16]}, 32'd255);
    for (int k = 0; k < DEPTH; k++) begin
      stat_write(32'h7); tick(); check_all($sformatf("drain%0d", k));
    end

    d_fault(32'ha0, 0, 0); tick();
    d_fault(32'hb0, 1, 0); tick();
    stat_write(32'hb); d_fault(32'hc0, 1, 0); tick(); check_all("clear");

    stat_write(32'h2); tick();
    d_fault(32'he0, 1, 1); i_fault(32'he4, 1); tick(); check_all("en_off");

    stat_write(32'h3); tick();
    d_fault(32'hf0, 0, 1); tick();
    read_csr(12'hbe5, v); cmp("unmapped", v, 32'h0);
    stat_write(32'h7); tick(); check_all("unmapped_pop");

`ifdef HAZARD3_PMP_FAULT_LOG_TIMESTAMP_EN
    d_fault(32'hd0, 0, 0); tick();
    repeat (4) tick();
    d_fault(32'hd4, 0, 0); tick();
    read_csr(12'hbe3, t0);
    stat_write(32'h7); tick();
    read_csr(12'hbe3, t1);
    cmp("ts_delta", t1 - t0, 32'd5);
    stat_write(32'h7); tick();
    read_csr(12'hbe3, v); cmp("ts_empty", v, 32'h0);
`else
    d_fault(32'hd0, 0, 0); tick();
    read_csr(12'hbe3, v); cmp("time_absent", v, 32'h0);
    t0 = v; t1 = v;
    stat_write(32'h7); tick();
`endif
    check_all("ts_done");

    d_fault(32'h7000, 1, 1); i_fault(32'h7004, 0); tick(); check_all("pre_reset");
    rst_n = 0; tick();
    rst_n = 1;
    check_all("reset_mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
